// File: rtl/soc_eq_solver_hps_ctrl_pio_if.sv
// Avalon-MM slave bus bundle between the HPS bridge and the control PIO.
// The master drives address/strobes/data; the slave returns combinational readdata.
interface soc_eq_solver_hps_ctrl_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_eq_solver_hps_ctrl_pio.sv
// Avalon-MM PIO for the solver fabric: a control register with atomic
// set/clear, and a synchronised status bus with per-bit edge capture and a
// maskable, registered level interrupt towards the HPS.
module soc_eq_solver_hps_ctrl_pio #(
  parameter int                   OUT_WIDTH   = 8,
  parameter int                   IN_WIDTH    = 8,
  parameter int                   EDGE_TYPE   = 0,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [OUT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  soc_eq_solver_hps_ctrl_pio_if.slave       bus,
  input  logic [IN_WIDTH-1:0]               in_port,
  output logic [OUT_WIDTH-1:0]              out_port,
  output logic                              irq
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  logic                                  wr;
  logic                                  rd;
  logic [OUT_WIDTH-1:0]                  data_out_reg;
  logic [OUT_WIDTH-1:0]                  data_out_next;
  logic [IN_WIDTH-1:0]                   mask_reg;
  logic [IN_WIDTH-1:0]                   mask_next;
  logic [IN_WIDTH-1:0]                   edgecap_reg;
  logic [IN_WIDTH-1:0]                   edgecap_next;
  logic [IN_WIDTH-1:0]                   w1c;
  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0]  sync_reg;
  logic [IN_WIDTH-1:0]                   sync_last;
  logic [IN_WIDTH-1:0]                   prev_reg;
  logic [IN_WIDTH-1:0]                   edge_evt;
  logic [ARM_W-1:0]                      arm_cnt_reg;
  logic                                  armed;
  logic                                  irq_reg;
  logic                                  unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign rd        = bus.chipselect & bus.write_n;
  assign sync_last = sync_reg[SYNC_STAGES-1];
  assign armed     = (arm_cnt_reg == ARM_W'(ARM_MAX));
  assign out_port  = data_out_reg;
  assign irq       = irq_reg;
  // Upper writedata bits beyond the register widths are deliberately ignored.
  assign unused_wd = ^bus.writedata;

  // Per-bit event selection; the edge type is fixed at elaboration.
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_evt = sync_last & ~prev_reg;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_evt = ~sync_last & prev_reg;
    end else begin : g_any
      assign edge_evt = sync_last ^ prev_reg;
    end
  endgenerate

  // Register-file write decode and edge-capture next state (a new edge beats W1C).
  always_comb begin
    data_out_next = data_out_reg;
    mask_next     = mask_reg;
    w1c           = '0;
    if (wr) begin
      case (bus.address)
        3'd0:    data_out_next = bus.writedata[OUT_WIDTH-1:0];
        3'd2:    mask_next     = bus.writedata[IN_WIDTH-1:0];
        3'd3:    w1c           = bus.writedata[IN_WIDTH-1:0];
        3'd4:    data_out_next = data_out_reg | bus.writedata[OUT_WIDTH-1:0];
        3'd5:    data_out_next = data_out_reg & ~bus.writedata[OUT_WIDTH-1:0];
        default: ;
      endcase
    end
    edgecap_next = (edgecap_reg & ~w1c) | (armed ? edge_evt : '0);
  end

  // Input synchroniser chain plus the one-cycle delayed copy used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
      prev_reg <= sync_last;
    end
  end

  // Post-reset arm counter: holds off capture until the chain has flushed reset-time levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_reg <= '0;
    end else if (!armed) begin
      arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
    end
  end

  // Control, mask and capture registers; irq is registered from next state so it is glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_reg <= RESET_VALUE;
      mask_reg     <= '0;
      edgecap_reg  <= '0;
      irq_reg      <= 1'b0;
    end else begin
      data_out_reg <= data_out_next;
      mask_reg     <= mask_next;
      edgecap_reg  <= edgecap_next;
      irq_reg      <= |(edgecap_next & mask_next);
    end
  end

  // Zero-wait-state read mux; unselected or unmapped reads return zero.
  always_comb begin
    bus.readdata = '0;
    if (rd) begin
      case (bus.address)
        3'd0:    bus.readdata[IN_WIDTH-1:0]  = sync_last;
        3'd1:    bus.readdata[OUT_WIDTH-1:0] = data_out_reg;
        3'd2:    bus.readdata[IN_WIDTH-1:0]  = mask_reg;
        3'd3:    bus.readdata[IN_WIDTH-1:0]  = edgecap_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_eq_solver_hps_ctrl_pio.sv
// Self-checking bench: two PIO instances (rising-edge and any-edge capture)
// share one stimulus stream and are compared every cycle against a
// history-based reference model.
module tb_soc_eq_solver_hps_ctrl_pio;
  localparam int         S  = 3;
  localparam logic [7:0] RV = 8'h3C;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  t_addr = '0;
  logic        t_cs = 1'b0;
  logic        t_wn = 1'b1;
  logic [31:0] t_wd = '0;
  logic [7:0]  in_port = 8'hFF;
  logic [7:0]  op0, op1;
  logic        irq0, irq1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soc_eq_solver_hps_ctrl_pio_if bus0 ();
  soc_eq_solver_hps_ctrl_pio_if bus1 ();

  assign bus0.address    = t_addr;
  assign bus0.chipselect = t_cs;
  assign bus0.write_n    = t_wn;
  assign bus0.writedata  = t_wd;
  assign bus1.address    = t_addr;
  assign bus1.chipselect = t_cs;
  assign bus1.write_n    = t_wn;
  assign bus1.writedata  = t_wd;

  soc_eq_solver_hps_ctrl_pio #(
    .OUT_WIDTH(8), .IN_WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(S), .RESET_VALUE(RV)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave),
    .in_port(in_port), .out_port(op0), .irq(irq0)
  );

  soc_eq_solver_hps_ctrl_pio #(
    .OUT_WIDTH(8), .IN_WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(S), .RESET_VALUE(RV)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave),
    .in_port(in_port), .out_port(op1), .irq(irq1)
  );

  // ---------------- reference model ----------------
  int         m_et [2] = '{0, 2};
  logic [7:0] m_out [2];
  logic [7:0] m_mask [2];
  logic [7:0] m_cap [2];
  logic       m_irq [2];
  logic [7:0] hist [$];   // hist[0] = in_port sampled at the most recent edge
  int         n_edges;

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d]  = RV;
      m_mask[d] = 8'h00;
      m_cap[d]  = 8'h00;
      m_irq[d]  = 1'b0;
    end
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(8'h00);
    n_edges = 0;
  endfunction

  function automatic logic [31:0] model_read(int d);
    if (!(t_cs && t_wn)) return 32'h0;
    case (t_addr)
      3'd0:    return {24'h0, hist[S-1]};
      3'd1:    return {24'h0, m_out[d]};
      3'd2:    return {24'h0, m_mask[d]};
      3'd3:    return {24'h0, m_cap[d]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step();
    logic [7:0] s, p, ev;
    s = hist[S-1];
    p = hist[S];
    for (int d = 0; d < 2; d++) begin
      case (m_et[d])
        0:       ev = s & ~p;
        1:       ev = ~s & p;
        default: ev = s ^ p;
      endcase
      if (n_edges < S + 1) ev = 8'h00;
      if (t_cs && !t_wn) begin
        case (t_addr)
          3'd0: m_out[d]  = t_wd[7:0];
          3'd2: m_mask[d] = t_wd[7:0];
          3'd3: m_cap[d]  = m_cap[d] & ~t_wd[7:0];
          3'd4: m_out[d]  = m_out[d] | t_wd[7:0];
          3'd5: m_out[d]  = m_out[d] & ~t_wd[7:0];
          default: ;
        endcase
      end
      m_cap[d] = m_cap[d] | ev;
      m_irq[d] = |(m_cap[d] & m_mask[d]);
    end
    hist.push_front(in_port);
    void'(hist.pop_back());
    if (n_edges < S + 1) n_edges++;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: readdata checked before the edge, registered outputs after it.
  task automatic tick();
    #1;
    check("rd0", bus0.readdata, model_read(0));
    check("rd1", bus1.readdata, model_read(1));
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    check("out0", {24'h0, op0}, {24'h0, m_out[0]});
    check("out1", {24'h0, op1}, {24'h0, m_out[1]});
    check("irq0", {31'h0, irq0}, {31'h0, m_irq[0]});
    check("irq1", {31'h0, irq1}, {31'h0, m_irq[1]});
  endtask

  task automatic idle(input int n);
    t_cs = 1'b0;
    t_wn = 1'b1;
    repeat (n) tick();
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    t_addr = a; t_cs = 1'b1; t_wn = 1'b0; t_wd = d;
    $display("WR addr=%0d data=%h in=%h", a, d, in_port);
    tick();
    t_cs = 1'b0; t_wn = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    t_addr = a; t_cs = 1'b1; t_wn = 1'b1; t_wd = '0;
    $display("RD addr=%0d exp0=%h exp1=%h", a, model_read(0), model_read(1));
    tick();
    t_cs = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic mid_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_out0", {24'h0, op0}, {24'h0, RV});
    check("rst_irq0", {31'h0, irq0}, 32'h0);
    check("rst_irq1", {31'h0, irq1}, 32'h0);
    t_cs = 1'b1; t_wn = 1'b1;
    t_addr = 3'd6; #1;
    check("rst_rd6", bus0.readdata, 32'h0);
    t_addr = 3'd7; #1;
    check("rst_rd7", bus1.readdata, 32'h0);
    t_addr = 3'd3; #1;
    check("rst_cap0", bus0.readdata, 32'h0);
    t_cs = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    reset_n = 1'b1;
    $display("RESET released");
  endtask

  initial begin
    model_reset();
    // 1: reset with inputs held high; no spurious edges once released.
    repeat (3) tick();
    reset_n = 1'b1;
    idle(10);
    check("t1_out", {24'h0, op0}, {24'h0, RV});
    bus_rd(3'd3);

    // 2: DATA / OUTSET / OUTCLR.
    bus_wr(3'd0, 32'hFFFF_FFA5);
    check("t2_data", {24'h0, op0}, 32'hA5);
    bus_wr(3'd4, 32'h0000_000A);
    check("t2_set", {24'h0, op0}, 32'hAF);
    bus_wr(3'd5, 32'h0000_0081);
    check("t2_clr", {24'h0, op0}, 32'h2E);
    t_addr = 3'd1; t_cs = 1'b1; t_wn = 1'b1; #1;
    check("t2_outrb", bus0.readdata, 32'h2E);
    bus_rd(3'd1);

    // 3: bit0 rising edge latency and W1C.
    bus_wr(3'd2, 32'h01);
    in_port = 8'h00;
    idle(S + 2);
    bus_wr(3'd3, 32'hFF);
    idle(1);
    in_port = 8'h01;
    idle(S);
    check("t3_irq_early", {31'h0, irq0}, 32'h0);
    idle(1);
    check("t3_irq_on", {31'h0, irq0}, 32'h1);
    bus_rd(3'd3);
    bus_wr(3'd3, 32'h01);
    check("t3_irq_off", {31'h0, irq0}, 32'h0);

    // 4: W1C in the same cycle as a new edge on bit0: set wins.
    in_port = 8'h00;
    idle(S + 2);
    bus_wr(3'd3, 32'hFF);
    in_port = 8'h01;
    idle(S);
    bus_wr(3'd3, 32'h01);
    check("t4_irq", {31'h0, irq0}, 32'h1);
    t_addr = 3'd3; t_cs = 1'b1; t_wn = 1'b1; #1;
    check("t4_cap0", {31'h0, bus0.readdata[0]}, 32'h1);
    bus_rd(3'd3);

    // 5: one-cycle pulse on bit1, any-edge instance captures both edges; mask=0 silences irq.
    bus_wr(3'd3, 32'hFF);
    idle(S + 2);
    in_port = 8'h03;
    tick();
    in_port = 8'h01;
    idle(S + 3);
    t_addr = 3'd3; t_cs = 1'b1; t_wn = 1'b1; #1;
    check("t5_cap1", {31'h0, bus1.readdata[1]}, 32'h1);
    bus_rd(3'd3);
    bus_wr(3'd2, 32'h00);
    check("t5_irq_masked", {31'h0, irq1}, 32'h0);
    bus_rd(3'd3);

    // 6: fill edgecap, then reset mid-sequence.
    bus_wr(3'd2, 32'hFF);
    in_port = 8'h00;
    idle(S + 2);
    in_port = 8'hFF;
    idle(S + 2);
    t_addr = 3'd3; t_cs = 1'b1; t_wn = 1'b1; #1;
    check("t6_capff", bus0.readdata, 32'hFF);
    bus_wr(3'd4, 32'h41);
    mid_reset();
    idle(S + 3);
    bus_rd(3'd3);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      t_cs   = ($urandom_range(0, 3) != 0);
      t_wn   = ($urandom_range(0, 1) != 0);
      t_addr = 3'($urandom_range(0, 7));
      t_wd   = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom);
      if (i == 700) begin
        t_cs = 1'b0;
        mid_reset();
      end else begin
        tick();
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
